// File: rtl/l2_controller.sv
// l2_controller: word-addressed L2 storage behind the coherence unit.
// Accesses take HIT_LAT cycles when the request falls in the most recently
// completed 16-word block, and MISS_LAT cycles otherwise.
`timescale 1ns/1ps
module l2_controller #(
  parameter int n        = 32,
  parameter int HIT_LAT  = 1,
  parameter int MISS_LAT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         L2_read_request,
  input  logic         L2_write_request,
  input  logic [14:0]  L2_word_address,
  input  logic [n-1:0] L2_rdata,
  output logic [n-1:0] L2_wdata,
  output logic         L2_busy
);

  localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [10:0]        blk_q, blk_d;
  logic               blk_v_q, blk_v_d;
  logic [n-1:0]       wdata_q, wdata_d;

  // Captured request: plain data registers, only meaningful while in ACCESS
  logic [14:0]        addr_q;
  logic [n-1:0]       data_q;
  logic               wr_q;

  logic               req;
  logic               hit;
  logic               cap_en;
  logic               mem_we;

  logic [n-1:0]       mem [0:(1<<15)-1];

  assign req      = L2_read_request | L2_write_request;
  assign hit      = blk_v_q && (L2_word_address[14:4] == blk_q);
  assign L2_busy  = (state_q == ACCESS);
  assign L2_wdata = wdata_q;

  // Next-state, counter, open-block and output-word logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    blk_v_d = blk_v_q;
    wdata_d = wdata_q;
    cap_en  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cap_en  = 1'b1;
          state_d = ACCESS;
          cnt_d   = hit ? CNT_W'(HIT_LAT - 1) : CNT_W'(MISS_LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          blk_d   = addr_q[14:4];
          blk_v_d = 1'b1;
          mem_we  = wr_q;
          // Writes forward the stored word so the requester sees it directly
          wdata_d = wr_q ? data_q : mem[addr_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        // A request still held from the finished access must not be re-accepted
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and the output word, cleared by asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      blk_v_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      blk_v_q <= blk_v_d;
      wdata_q <= wdata_d;
    end
  end

  // Request capture and storage array; neither is affected by reset
  always_ff @(posedge clock) begin
    if (cap_en) begin
      addr_q <= L2_word_address;
      data_q <= L2_rdata;
      wr_q   <= L2_write_request;
    end
    if (mem_we) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_l2_controller.sv
// tb_l2_controller: directed requests with a scoreboard; the monitor measures
// each busy pulse and checks its length and the returned word.
`timescale 1ns/1ps
module tb_l2_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_r  = 1'b0;
  logic        wr_r  = 1'b0;
  logic [14:0] addr_r = '0;
  logic [31:0] data_r = '0;
  logic [31:0] L2_wdata;
  logic        L2_busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          lat;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];

  l2_controller #(.n(32), .HIT_LAT(1), .MISS_LAT(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .L2_read_request  (rd_r),
    .L2_write_request (wr_r),
    .L2_word_address  (addr_r),
    .L2_rdata         (data_r),
    .L2_wdata         (L2_wdata),
    .L2_busy          (L2_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: count busy-high samples, score each completed access on busy fall
  initial begin
    int hi;
    exp_t e;
    hi = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hi = 0;
      end else if (L2_busy) begin
        hi++;
      end else if (hi > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access", 32'(hi), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", 32'(hi), 32'(e.lat));
          if (e.chk_data) check("wdata", L2_wdata, e.data);
        end
        hi = 0;
      end
    end
  end

  // Issue one request, hold it until busy falls plus 'hold' cycles, then drop it
  task automatic access(input bit rd, input bit wr, input logic [14:0] a,
                        input logic [31:0] d, input int lat,
                        input logic [31:0] ed, input bit chk_data, input int hold);
    exp_t e;
    bit seen, done;
    e.lat = lat; e.data = ed; e.chk_data = chk_data;
    exp_q.push_back(e);
    @(negedge clock);
    rd_r = rd; wr_r = wr; addr_r = a; data_r = d;
    seen = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (L2_busy) seen = 1;
      else if (seen) done = 1;
    end
    if (!done) check("busy_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("held_req_busy", {31'd0, L2_busy}, 32'd0);
    end
    rd_r = 0; wr_r = 0;
  endtask

  initial begin
    // Reset state and idle behaviour
    #12;
    check("reset_busy", {31'd0, L2_busy}, 32'd0);
    check("reset_wdata", L2_wdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_busy", {31'd0, L2_busy}, 32'd0);
      check("idle_wdata", L2_wdata, 32'd0);
    end

    access(0, 1, 15'd70,   32'd5,   4, 32'd5,   1, 0); // first access: miss
    access(1, 0, 15'd70,   32'd0,   1, 32'd5,   1, 0); // same block: hit
    access(1, 0, 15'd71,   32'd0,   1, 32'd0,   0, 0); // hit, contents unknown
    access(1, 0, 15'd1030, 32'd0,   4, 32'd0,   0, 0); // other block: miss
    access(1, 0, 15'd70,   32'd0,   4, 32'd5,   1, 0); // back to 70: miss
    access(1, 1, 15'd70,   32'd9,   1, 32'd9,   1, 8); // both requests, held
    access(1, 0, 15'd70,   32'd0,   1, 32'd9,   1, 0);
    access(0, 1, 15'd200,  32'd0,   4, 32'd0,   1, 0);
    access(0, 1, 15'd71,   32'h1234,4, 32'h1234,1, 0);
    access(1, 0, 15'd71,   32'd0,   1, 32'h1234,1, 0);

    // Reset two cycles into a write of 7 to address 200
    @(negedge clock);
    wr_r = 1; addr_r = 15'd200; data_r = 32'd7;
    @(negedge clock);
    check("abort_busy_pre", {31'd0, L2_busy}, 32'd1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, L2_busy}, 32'd0);
    check("abort_wdata", L2_wdata, 32'd0);
    wr_r = 0;
    @(negedge clock);
    #1 reset = 1'b0;

    access(1, 0, 15'd200,  32'd0,   4, 32'd0,   1, 0); // blk_v cleared: miss, 7 not stored

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_controller.md
# l2_controller

Word-addressed L2 storage controller sitting directly downstream of the two-core coherence unit. It consumes the single arbitrated request the coherence unit forwards (read or write, 15-bit word address, write data) and returns read data plus a busy handshake. An open-block buffer makes re-accesses to the most recently used 16-word block complete faster than accesses to other blocks.

## Interface
- n, 32, data word width
- HIT_LAT, 1, ACCESS cycles when the block matches the open-block buffer (≥1)
- MISS_LAT, 4, ACCESS cycles otherwise (≥HIT_LAT)
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- L2_read_request  input  1  read request from coherence unit (level)
- L2_write_request  input  1  write request from coherence unit (level)
- L2_word_address  input  15  word address; [14:10] tag, [9:4] index, [3:0] word offset
- L2_rdata  input  n  word to store (write requests)
- L2_wdata  output  n  word returned to the requesting L1
- L2_busy  output  1  high while an access is in progress; drives the coherence unit's L2_busy_in

## Operation
- Storage: 2^15 × n array, not reset. Open-block buffer: register blk[10:0] plus valid bit blk_v.
- State machine: IDLE, ACCESS, DONE.
- IDLE: L2_busy=0. If either request is high at a rising edge: capture address, L2_rdata, op (write if L2_write_request, else read); load counter with HIT_LAT-1 if blk_v && address[14:4]==blk, else MISS_LAT-1; go to ACCESS.
- ACCESS: L2_busy=1. Counter decrements each edge. On the edge where counter==0: perform op on captured address, set blk=captured address[14:4], blk_v=1, go to DONE.
  - Read: L2_wdata <= mem[addr].
  - Write: mem[addr] <= captured data; L2_wdata <= captured data (forwarding).
- DONE: L2_busy=0. Stay while either request is high (no re-accept of a held request). Go to IDLE on the first edge where both are low.
- Request inputs are ignored in ACCESS; captured values alone determine the access, so input changes mid-access have no effect.
- Simultaneous read and write requests: treated as a write; the written word is returned on L2_wdata.
- L2_wdata holds its value until the next completed access; it is not cleared in IDLE.

## Timing
- Reset (asynchronous, immediate): state=IDLE, L2_busy=0, L2_wdata=0, blk_v=0, blk=0, counter=0. Memory contents are unchanged.
- Reset asserted during ACCESS aborts the access. No memory write occurs unless the completion edge has already passed.
- Accept edge E0: L2_busy rises after E0 and stays high for exactly L cycles (L = HIT_LAT or MISS_LAT). At edge E0+L, L2_busy falls and L2_wdata is valid.
- Minimum request-to-request spacing: L + 2 cycles (L ACCESS, ≥1 DONE, 1 IDLE).
- L2_busy is a registered state decode with no combinational path from the request inputs.
- Hit test uses the blk value present at the accept edge. An access that completes updates blk for the next accept.
- Address wrap: none; all 2^15 addresses are valid, and offset bits never affect hit/miss.

## Test plan
- Reset, then hold the request inputs low for 3 cycles -> L2_busy=0, L2_wdata=0, no state change.
- Write 5 to address 70 (first access after reset), then drop the request after busy falls -> busy high exactly 4 cycles; L2_wdata=5 after completion.
- Read address 70, then read address 71 (same block) -> first read: busy high 1 cycle, L2_wdata=5; second read: busy 1 cycle, L2_wdata=previous mem[71].
- Read address 1030 (different block) after the above -> busy high 4 cycles; a following read of 70 also takes 4 cycles.
- Assert both requests with address 70 and L2_rdata=9, holding them for 10 cycles -> one access only; busy high 1 cycle then low for the rest of the hold; L2_wdata=9; a later read of 70 returns 9.
- Assert reset 2 cycles into a 4-cycle write to address 200 with data 7 -> L2_busy=0 and L2_wdata=0 immediately; a later read of 200 does not return 7 (if previously written as 0) and takes 4 cycles because blk_v was cleared.
